alu_dispatch_ctrl: RTL and testbench
====================================

// Module: alu_dispatch_ctrl
// PURPOSE
//  Front-end issue/sequencing controller for the ALU datapath; the producer side of the result-select mux.
//  Accepts one funct-coded op per handshake and registers the funct code that drives the mux select.
//  Owns the HI/LO registers and runs DIVU as a multi-cycle serial restoring divide.
//  Single-cycle ops complete in 1 cycle; DIVU completes in WIDTH+1 cycles.
// PARAMETERS
//  WIDTH  32               operand / HI / LO width
//  CNT_W  $clog2(WIDTH)+1  divide-step counter width (derived, do not override)
// PORTS
//  clk         in   1      system clock, all state on rising edge
//  rst_n       in   1      asynchronous active-low reset
//  in_valid    in   1      op request valid
//  in_ready    out  1      controller can accept an op this cycle
//  funct       in   6      op code: AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010, SRL 000010, DIVU 011011, MFHI 010000, MFLO 010010
//  op_a        in   WIDTH  dividend for DIVU (ignored otherwise)
//  op_b        in   WIDTH  divisor for DIVU (ignored otherwise)
//  sel_funct   out  6      registered funct, drives result-mux Signal
//  out_valid   out  1      1-cycle pulse: result for sel_funct is valid
//  hi_out      out  WIDTH  HI register (remainder)
//  lo_out      out  WIDTH  LO register (quotient)
//  illegal     out  1      with out_valid: funct not in the legal set
//  div_zero    out  1      with out_valid: DIVU had op_b==0 (0 unless DIV_ZERO_TRAP_EN)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, sel_funct=0, out_valid=0, illegal=0, div_zero=0, hi_out=lo_out=0, counter=0.
//  Handshake: accept on in_valid&&in_ready. in_ready=1 only in IDLE. Request held stable until accepted.
//  FSM IDLE->ISSUE (non-DIVU accept), IDLE->DIV (DIVU accept), ISSUE->IDLE, DIV->DONE (counter==WIDTH), DONE->IDLE.
//  ISSUE: sel_funct<=funct on accept; out_valid=1 for exactly the next cycle; no HI/LO change.
//  Back-to-back single-cycle ops: in_ready=0 in ISSUE, so max throughput is 1 op per 2 cycles.
//  Unknown funct: treated as single-cycle; illegal=1 alongside out_valid; sel_funct=funct passed through.
//  DIV: restoring divide, 1 quotient bit/cycle MSB first, rem=(rem<<1)|dividend[msb]; if rem>=divisor {rem-=divisor; q bit=1}.
//   Remainder datapath is WIDTH+1 bits to hold the pre-subtract value. counter counts 0..WIDTH.
//  DONE: lo_out<=quotient, hi_out<=remainder, sel_funct=DIVU, out_valid=1 for this cycle only.
//   Total: accept at cycle 0 -> out_valid at cycle WIDTH+1.
//  HI/LO hold their prior values during DIV. They update only in DONE.
//  MFHI/MFLO issued after DIVU see the new values because in_ready stays 0 until DONE has written HI/LO.
//  rst_n asserted mid-DIV aborts the divide. HI/LO clear to 0 and no out_valid is produced.
//  out_valid, illegal and div_zero are all 0 in IDLE and DIV.
// CONFIGURATION
//  DIV_ZERO_TRAP_EN defined: DIVU with op_b==0 goes IDLE->DONE in 1 cycle.
//   In that case HI/LO are unchanged and div_zero=1 with out_valid.
//  DIV_ZERO_TRAP_EN undefined: the divide runs the full WIDTH steps with no special case.
//   Result is lo_out='1 (all ones) and hi_out=op_a. div_zero is tied to 0.
// STRUCTURE
//  Package alu_funct_pkg holds:
//   - the FUNCT_* 6-bit constants (shared with the result mux and the decoder);
//   - the state encoding IDLE/ISSUE/DIV/DONE.
//  Sub-module divu_serial holds the restoring divider.
//   Ports: start, dividend, divisor, done, quotient, remainder. Same clk/rst_n.
//  The top level holds the FSM, handshake, and HI/LO registers.
// TESTING
//  1. Reset: rst_n=0 with random inputs -> all outputs 0 and in_ready=1 after release.
//  2. ADD (100000) accepted at cycle 0 -> sel_funct=100000, out_valid=1 at cycle 1 only; hi/lo unchanged.
//     in_ready=0 at cycle 1 and 1 again at cycle 2.
//  3. DIVU op_a=100, op_b=7 -> out_valid at cycle 33, lo_out=14, hi_out=2; in_ready=0 for cycles 1..33.
//     Follow with MFHI -> sel_funct=010000 and hi_out=2.
//  4. DIVU op_a=32'hFFFFFFFF, op_b=1 -> lo_out=32'hFFFFFFFF, hi_out=0.
//     Then DIVU 5/9 -> lo_out=0, hi_out=5.
//  5. DIVU op_b=0, op_a=55:
//     - with DIV_ZERO_TRAP_EN: out_valid at cycle 1, div_zero=1, hi/lo unchanged;
//     - without it: cycle 33, lo_out=32'hFFFFFFFF, hi_out=55.
//  6. Abort and illegal op: DIVU 1000/3, then rst_n=0 at cycle 10 -> hi/lo=0, no out_valid.
//     Next, funct=111111 -> out_valid with illegal=1.

Source files
------------

// File: rtl/alu_funct_pkg.sv
// Shared funct encodings and dispatch FSM state encoding for the ALU front end.
// Imported by the dispatch controller, the result mux and the decoder.
package alu_funct_pkg;

  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_DIVU = 6'b011011;
  localparam logic [5:0] FUNCT_MFHI = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO = 6'b010010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DIV   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic is_legal_funct(input logic [5:0] f);
    logic ok;
    case (f)
      FUNCT_AND, FUNCT_OR, FUNCT_ADD, FUNCT_SUB, FUNCT_SLT,
      FUNCT_SRL, FUNCT_DIVU, FUNCT_MFHI, FUNCT_MFLO: ok = 1'b1;
      default:                                       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/divu_serial.sv
// Serial restoring unsigned divider, one quotient bit per cycle, MSB first.
// The first step is folded into the start cycle, so done rises WIDTH cycles after start.
module divu_serial
  import alu_funct_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quot;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;

  logic [WIDTH-1:0] w_rem_in;
  logic [WIDTH-1:0] w_dvs;
  logic             w_bit;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_next;
  logic             w_last;

  // On start the step works on the incoming operands with a zero partial remainder.
  assign w_rem_in = start ? '0 : r_rem;
  assign w_dvs    = start ? divisor : r_dvs;
  assign w_bit    = start ? dividend[WIDTH-1] : r_dvd[WIDTH-1];

  // Shifted partial remainder needs one extra bit before the compare.
  assign w_shift  = {w_rem_in, w_bit};
  assign w_ge     = (w_shift >= {1'b0, w_dvs});
  // When w_ge holds the true difference is below the divisor, so WIDTH bits suffice.
  assign w_rem_next = w_ge ? (w_shift[WIDTH-1:0] - w_dvs) : w_shift[WIDTH-1:0];

  assign w_last = (r_cnt == CNT_W'(WIDTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_rem  <= '0;
      r_quot <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start) begin
      r_dvd  <= {dividend[WIDTH-2:0], 1'b0};
      r_dvs  <= divisor;
      r_rem  <= w_rem_next;
      r_quot <= {{(WIDTH-1){1'b0}}, w_ge};
      r_cnt  <= CNT_W'(1);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (w_last) begin
        r_busy <= 1'b0;
      end else begin
        r_dvd  <= {r_dvd[WIDTH-2:0], 1'b0};
        r_rem  <= w_rem_next;
        r_quot <= {r_quot[WIDTH-2:0], w_ge};
        r_cnt  <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign done      = r_busy && w_last;
  assign quotient  = r_quot;
  assign remainder = r_rem;

endmodule

// File: rtl/alu_dispatch_ctrl.sv
// ALU issue/sequencing controller: funct handshake, result-mux select, HI/LO and serial DIVU.
// Optional DIV_ZERO_TRAP_EN: DIVU by zero completes in one cycle with div_zero and HI/LO untouched.
module alu_dispatch_ctrl
  import alu_funct_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [5:0]       sel_funct,
  output logic             out_valid,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             illegal,
  output logic             div_zero,
  output logic [1:0]       o_dbg_state
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  // Handshake: an op transfers on a cycle with in_valid && in_ready; in_ready is
  // high only in IDLE, and the requester holds funct/op_a/op_b stable until then.

  state_t           r_state;
  state_t           w_next_state;
  logic [5:0]       r_sel_funct;
  logic             r_illegal;
  logic             r_div_zero;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_accept;
  logic             w_is_divu;
  logic             w_dz;
  logic             w_div_start;
  logic             w_div_done;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;

  assign w_accept  = in_valid && in_ready;
  assign w_is_divu = (funct == FUNCT_DIVU);

`ifdef DIV_ZERO_TRAP_EN
  assign w_dz = w_is_divu && (op_b == '0);
`else
  assign w_dz = 1'b0;
`endif

  assign w_div_start = w_accept && w_is_divu && !w_dz;

  divu_serial #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_divu (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (w_div_start),
    .dividend  (op_a),
    .divisor   (op_b),
    .done      (w_div_done),
    .quotient  (w_quot),
    .remainder (w_rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_is_divu) w_next_state = w_dz ? ST_DONE : ST_DIV;
          else           w_next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: w_next_state = ST_IDLE;
      ST_DIV:   if (w_div_done) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    illegal   = 1'b0;
    div_zero  = 1'b0;
    case (r_state)
      ST_IDLE:  in_ready = 1'b1;
      ST_ISSUE: begin
        out_valid = 1'b1;
        illegal   = r_illegal;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        div_zero  = r_div_zero;
      end
      default: ;
    endcase
  end

  // Op attributes are captured at accept and qualified by state on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_funct <= '0;
      r_illegal   <= 1'b0;
      r_div_zero  <= 1'b0;
    end else if (w_accept) begin
      r_sel_funct <= funct;
      r_illegal   <= !is_legal_funct(funct);
      r_div_zero  <= w_dz;
    end
  end

  // HI/LO land on the DIV->DONE edge so they are already valid alongside out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if ((r_state == ST_DIV) && w_div_done) begin
      r_hi <= w_rem;
      r_lo <= w_quot;
    end
  end

  assign sel_funct   = r_sel_funct;
  assign hi_out      = r_hi;
  assign lo_out      = r_lo;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_dispatch_ctrl.sv
// Directed self-checking bench for alu_dispatch_ctrl (WIDTH=32).
// Honours DIV_ZERO_TRAP_EN when it is defined for the build.
module tb_alu_dispatch_ctrl;

  localparam int W = 32;

  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_DIVU = 6'b011011;
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MFLO = 6'b010010;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [5:0]   funct;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [5:0]   sel_funct;
  logic         out_valid;
  logic [W-1:0] hi_out;
  logic [W-1:0] lo_out;
  logic         illegal;
  logic         div_zero;
  logic [1:0]   dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  alu_dispatch_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .funct       (funct),
    .op_a        (op_a),
    .op_b        (op_b),
    .sel_funct   (sel_funct),
    .out_valid   (out_valid),
    .hi_out      (hi_out),
    .lo_out      (lo_out),
    .illegal     (illegal),
    .div_zero    (div_zero),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    funct    = f;
    op_a     = a;
    op_b     = b;
    step();
    in_valid = 1'b0;
    funct    = 6'($urandom_range(0, 63));
    op_a     = $urandom;
    op_b     = $urandom;
  endtask

  // Entered at cycle 1 after an accept; lat is the cycle where out_valid is seen, -1 on timeout.
  task automatic wait_out(input int max_cyc, output int lat, output int ready_hi);
    bit found;
    found    = 1'b0;
    lat      = -1;
    ready_hi = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      if (!found) begin
        if (out_valid === 1'b1) begin
          lat   = i;
          found = 1'b1;
        end else begin
          if (in_ready !== 1'b0) ready_hi++;
          step();
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'($urandom_range(0, 1));
    funct    = 6'($urandom_range(0, 63));
    op_a     = $urandom;
    op_b     = $urandom;
    repeat (3) step();
    n_tests++;
    if ({sel_funct, out_valid, illegal, div_zero} !== 9'd0 || hi_out !== '0 || lo_out !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: sel=%b ov=%b ill=%b dz=%b hi=%h lo=%h, want all 0",
               sel_funct, out_valid, illegal, div_zero, hi_out, lo_out);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step();
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b ov=%b state=%0d, want 1 0 0", in_ready, out_valid, dbg_state);
    end
  endtask

  task automatic test_add();
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL add_ready_c0: in_ready=%b want 1", in_ready);
    end
    accept_op(F_ADD, 32'h1234, 32'h5678);
    n_tests++;
    if (out_valid !== 1'b1 || sel_funct !== F_ADD || in_ready !== 1'b0 || illegal !== 1'b0
        || hi_out !== '0 || lo_out !== '0) begin
      n_fail++;
      $display("FAIL add_c1: ov=%b sel=%b rdy=%b ill=%b hi=%h lo=%h, want 1 100000 0 0 0 0",
               out_valid, sel_funct, in_ready, illegal, hi_out, lo_out);
    end
    step();
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL add_c2: ov=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_single_cycle_table();
    logic [5:0] ops [6];
    ops = '{F_AND, F_OR, F_SUB, F_SLT, F_SRL, F_MFLO};
    for (int k = 0; k < 6; k++) begin
      accept_op(ops[k], $urandom, $urandom);
      n_tests++;
      if (out_valid !== 1'b1 || sel_funct !== ops[k] || illegal !== 1'b0 || div_zero !== 1'b0) begin
        n_fail++;
        $display("FAIL single_op_%0d: ov=%b sel=%b ill=%b dz=%b, want 1 %b 0 0",
                 k, out_valid, sel_funct, illegal, div_zero, ops[k]);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1;
    funct    = F_OR;
    step();
    funct = F_SLT;
    n_tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || sel_funct !== F_OR) begin
      n_fail++;
      $display("FAIL b2b_c1: rdy=%b ov=%b sel=%b, want 0 1 %b", in_ready, out_valid, sel_funct, F_OR);
    end
    step();
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_c2: rdy=%b ov=%b, want 1 0", in_ready, out_valid);
    end
    step();
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || sel_funct !== F_SLT) begin
      n_fail++;
      $display("FAIL b2b_c3: ov=%b sel=%b, want 1 %b", out_valid, sel_funct, F_SLT);
    end
    step();
  endtask

  task automatic test_divu_basic();
    int lat, rhi;
    accept_op(F_DIVU, 32'd100, 32'd7);
    n_tests++;
    if (hi_out !== '0 || lo_out !== '0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL divu_hold: hi=%h lo=%h ov=%b, want 0 0 0", hi_out, lo_out, out_valid);
    end
    wait_out(40, lat, rhi);
    n_tests++;
    if (lat !== 33 || rhi !== 0) begin
      n_fail++;
      $display("FAIL divu_latency: lat=%0d ready_hi_cycles=%0d, want 33 0", lat, rhi);
    end
    n_tests++;
    if (lo_out !== 32'd14 || hi_out !== 32'd2 || sel_funct !== F_DIVU || div_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL divu_100_7: lo=%0d hi=%0d sel=%b dz=%b, want 14 2 %b 0",
               lo_out, hi_out, sel_funct, div_zero, F_DIVU);
    end
    step();
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL divu_after: ov=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
    accept_op(F_MFHI, '0, '0);
    n_tests++;
    if (out_valid !== 1'b1 || sel_funct !== F_MFHI || hi_out !== 32'd2) begin
      n_fail++;
      $display("FAIL mfhi: ov=%b sel=%b hi=%0d, want 1 %b 2", out_valid, sel_funct, hi_out, F_MFHI);
    end
    step();
  endtask

  task automatic test_divu_edges();
    int lat, rhi;
    accept_op(F_DIVU, 32'hFFFF_FFFF, 32'd1);
    wait_out(40, lat, rhi);
    n_tests++;
    if (lat !== 33 || lo_out !== 32'hFFFF_FFFF || hi_out !== 32'd0) begin
      n_fail++;
      $display("FAIL divu_max_1: lat=%0d lo=%h hi=%h, want 33 ffffffff 0", lat, lo_out, hi_out);
    end
    step();
    accept_op(F_DIVU, 32'd5, 32'd9);
    wait_out(40, lat, rhi);
    n_tests++;
    if (lat !== 33 || lo_out !== 32'd0 || hi_out !== 32'd5) begin
      n_fail++;
      $display("FAIL divu_5_9: lat=%0d lo=%0d hi=%0d, want 33 0 5", lat, lo_out, hi_out);
    end
    step();
  endtask

  task automatic test_div_zero();
    int lat, rhi;
    accept_op(F_DIVU, 32'd55, 32'd0);
    wait_out(40, lat, rhi);
`ifdef DIV_ZERO_TRAP_EN
    n_tests++;
    if (lat !== 1 || div_zero !== 1'b1 || lo_out !== 32'd0 || hi_out !== 32'd5 || sel_funct !== F_DIVU) begin
      n_fail++;
      $display("FAIL div_zero_trap: lat=%0d dz=%b lo=%0d hi=%0d sel=%b, want 1 1 0 5 %b",
               lat, div_zero, lo_out, hi_out, sel_funct, F_DIVU);
    end
`else
    n_tests++;
    if (lat !== 33 || div_zero !== 1'b0 || lo_out !== 32'hFFFF_FFFF || hi_out !== 32'd55) begin
      n_fail++;
      $display("FAIL div_zero_full: lat=%0d dz=%b lo=%h hi=%0d, want 33 0 ffffffff 55",
               lat, div_zero, lo_out, hi_out);
    end
`endif
    step();
  endtask

  task automatic test_abort_illegal();
    logic [W-1:0] prev_hi;
    int           ov_seen;
`ifdef DIV_ZERO_TRAP_EN
    prev_hi = 32'd5;
`else
    prev_hi = 32'd55;
`endif
    accept_op(F_DIVU, 32'd1000, 32'd3);
    repeat (9) step();
    n_tests++;
    if (hi_out !== prev_hi || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_pre: hi=%0d ov=%b rdy=%b, want %0d 0 0", hi_out, out_valid, in_ready, prev_hi);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (hi_out !== '0 || lo_out !== '0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_clear: hi=%h lo=%h ov=%b, want 0 0 0", hi_out, lo_out, out_valid);
    end
    step();
    rst_n   = 1'b1;
    ov_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0) ov_seen++;
      step();
    end
    n_tests++;
    if (ov_seen !== 0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_no_valid: out_valid_cycles=%0d rdy=%b, want 0 1", ov_seen, in_ready);
    end
    accept_op(6'b111111, '0, '0);
    n_tests++;
    if (out_valid !== 1'b1 || illegal !== 1'b1 || sel_funct !== 6'b111111 || hi_out !== '0) begin
      n_fail++;
      $display("FAIL illegal: ov=%b ill=%b sel=%b hi=%h, want 1 1 111111 0", out_valid, illegal, sel_funct, hi_out);
    end
    step();
    n_tests++;
    if (out_valid !== 1'b0 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_after: ov=%b ill=%b, want 0 0", out_valid, illegal);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_single_cycle_table();
    test_back_to_back();
    test_divu_basic();
    test_divu_edges();
    test_div_zero();
    test_abort_illegal();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
